// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions: widths, reset/trap vector defaults, fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: XLEN, ILEN_BYTES, RESET_VECTOR_DEF, TRAP_VECTOR_DEF, fetch_state_t,
// word_align(). The ST_TRAP state exists only when RV32I_FETCH_MISALIGN_TRAP_EN
// is defined.
package rv32i_pkg;

   localparam int XLEN       = 32;
   localparam int ILEN_BYTES = 4;

   localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam logic [XLEN-1:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
      ,ST_TRAP = 2'd3
`endif
   } fetch_state_t;

   // Clear the byte-offset bits of an address. Masking (instead of
   // concatenation) keeps every input bit referenced.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return a & ~XLEN'(ILEN_BYTES - 1);
   endfunction

endpackage

// File: rtl/rv32i_redirect_buf.sv
// Pending-redirect register: remembers a redirect that arrives while a fetch is still outstanding.
// Latency: set/clear visible on pend_valid/pend_target the cycle after the edge.
// Backpressure: none; a newer set overwrites the held target, set wins over clr.
//
// Ports: clk, reset (async, active-high), set + set_target (capture/overwrite),
// clr (drop pending entry), pend_valid / pend_target (held redirect).
module rv32i_redirect_buf
   import rv32i_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            set,
   input  logic [XLEN-1:0] set_target,
   input  logic            clr,
   output logic            pend_valid,
   output logic [XLEN-1:0] pend_target
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_valid  <= 1'b0;
         pend_target <= '0;
      end else if (set) begin
         pend_valid  <= 1'b1;
         pend_target <= set_target;
      end else if (clr) begin
         pend_valid  <= 1'b0;
      end
   end

endmodule

// File: rtl/rv32i_fetch_ctrl.sv
// Multicycle RV32I fetch sequencer: drives next_pc, handshakes imem, hands instructions to decode.
// Latency: BOOT 1 cycle; ack in a FETCH cycle -> instr_valid next cycle; best case 1 instr / 2 cycles.
// Backpressure: instr held stable in HOLD until instr_ready & ~stall; imem_req never withdrawn before ack.
//
// Ports: clk, reset (async, active-high), pc / next_pc (external PC register),
// imem_req/imem_addr/imem_ack/imem_rdata (instruction memory), instr/instr_pc/
// instr_valid/instr_ready/stall (decode), redirect_valid/redirect_target (execute),
// fetch_count (accepted instructions), misalign_fault (trap build only).
// Build option: RV32I_FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap;
// without it redirect targets are word-aligned by masking.
module rv32i_fetch_ctrl
   import rv32i_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] next_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic [XLEN-1:0] fetch_count
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
   ,
   output logic            misalign_fault
`endif
);

   fetch_state_t    state;
   logic            pend_valid;
   logic [XLEN-1:0] pend_target;
   logic [XLEN-1:0] rd_target;     // redirect target after the alignment policy
   logic            accept;
   logic            apply_redir;   // a live or pending redirect takes effect this cycle
   logic [XLEN-1:0] apply_target;
   logic            take_instr;
   logic            pend_set;
   logic            pend_clr;
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
   logic            trap_take;
   // Keep raw bits so a misaligned target can be detected when it is applied.
   assign rd_target = redirect_target;
`else
   assign rd_target = word_align(redirect_target);
`endif

   assign imem_addr = pc;
   // instr_valid is only ever high in HOLD, so this is HOLD-qualified already.
   assign accept    = instr_valid & instr_ready & ~stall;

   rv32i_redirect_buf u_redirect_buf (
      .clk         (clk),
      .reset       (reset),
      .set         (pend_set),
      .set_target  (rd_target),
      .clr         (pend_clr),
      .pend_valid  (pend_valid),
      .pend_target (pend_target)
   );

   always_comb begin
      next_pc      = pc;
      apply_redir  = 1'b0;
      apply_target = rd_target;
      take_instr   = 1'b0;
      pend_set     = 1'b0;
      pend_clr     = 1'b0;
      case (state)
         ST_BOOT: next_pc = RESET_VECTOR;
         ST_FETCH: begin
            if (imem_ack) begin
               // The outstanding fetch completes; any pending target is consumed
               // or superseded by a redirect arriving in the same cycle.
               pend_clr = 1'b1;
               if (redirect_valid) begin
                  apply_redir = 1'b1;
               end else if (pend_valid) begin
                  apply_redir  = 1'b1;
                  apply_target = pend_target;
               end else begin
                  take_instr = 1'b1;
               end
            end else if (redirect_valid) begin
               pend_set = 1'b1;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) apply_redir = 1'b1;
            else if (accept)    next_pc = pc + XLEN'(ILEN_BYTES);
         end
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
         ST_TRAP: next_pc = TRAP_VECTOR;
`endif
         default: next_pc = pc;
      endcase
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
      trap_take = apply_redir & (apply_target[1:0] != 2'b00);
      if (apply_redir & ~trap_take) next_pc = apply_target;
`else
      if (apply_redir) next_pc = apply_target;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_BOOT;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
         fetch_count <= '0;
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
         misalign_fault <= 1'b0;
`endif
      end else begin
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
         misalign_fault <= trap_take;
`endif
         case (state)
            ST_BOOT: begin
               state    <= ST_FETCH;
               imem_req <= 1'b1;
            end
            ST_FETCH: begin
               if (take_instr) begin
                  instr       <= imem_rdata;
                  instr_pc    <= pc;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  state       <= ST_HOLD;
               end
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
               else if (trap_take) begin
                  imem_req <= 1'b0;
                  state    <= ST_TRAP;
               end
`endif
            end
            ST_HOLD: begin
               if (apply_redir) begin
                  instr_valid <= 1'b0;
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
                  if (trap_take) begin
                     state <= ST_TRAP;
                  end else begin
                     imem_req <= 1'b1;
                     state    <= ST_FETCH;
                  end
`else
                  imem_req <= 1'b1;
                  state    <= ST_FETCH;
`endif
               end else if (accept) begin
                  fetch_count <= fetch_count + 1'b1;
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
                  state       <= ST_FETCH;
               end
            end
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
            ST_TRAP: begin
               imem_req <= 1'b1;
               state    <= ST_FETCH;
            end
`endif
            default: state <= ST_BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_fetch_ctrl.sv
// Directed bench for rv32i_fetch_ctrl: external PC register and a simple
// instruction memory (rdata = addr + 0x1000) are modelled here.
module tb_rv32i_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] fetch_count;
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
   logic        misalign_fault;
`endif

   logic ack_en;
   logic ack_force;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   // External PC register: loads next_pc every edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc <= 32'hDEAD_BEE0;
      else       pc <= next_pc;
   end

   // Zero-wait memory when enabled; ack_force injects a stray ack.
   assign imem_ack   = (imem_req & ack_en) | ack_force;
   assign imem_rdata = imem_addr + 32'h0000_1000;

   rv32i_fetch_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .pc              (pc),
      .next_pc         (next_pc),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .fetch_count     (fetch_count)
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
      ,
      .misalign_fault  (misalign_fault)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  pulses;
      bit  got;
      reset = 1'b1; ack_en = 1'b1; ack_force = 1'b0;
      instr_ready = 1'b1; stall = 1'b0;
      redirect_valid = 1'b0; redirect_target = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", imem_req, 32'd0);
      chk("rst_valid", instr_valid, 32'd0);
      chk("rst_count", fetch_count, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_pc", instr_pc, 32'd0);
      chk("boot_next_pc", next_pc, 32'h0);
      reset = 1'b0;

      // Streaming: pc 0, 4, 8 with ready high
      tick();
      chk("f0_req", imem_req, 32'd1);
      chk("f0_addr", imem_addr, 32'h0);
      chk("f0_valid", instr_valid, 32'd0);
      tick();
      chk("h0_valid", instr_valid, 32'd1);
      chk("h0_req", imem_req, 32'd0);
      chk("h0_instr", instr, 32'h0000_1000);
      chk("h0_instr_pc", instr_pc, 32'h0);
      chk("h0_next_pc", next_pc, 32'h4);
      tick();
      chk("f1_addr", imem_addr, 32'h4);
      chk("f1_valid", instr_valid, 32'd0);
      chk("f1_count", fetch_count, 32'd1);
      tick();
      chk("h1_instr_pc", instr_pc, 32'h4);
      tick();
      chk("f2_addr", imem_addr, 32'h8);
      tick();
      chk("h2_instr", instr, 32'h0000_1008);
      tick();
      chk("count3", fetch_count, 32'd3);
      chk("f3_addr", imem_addr, 32'hC);

      // Ready low for 5 HOLD cycles
      instr_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", instr_valid, 32'd1);
         chk("hold_instr", instr, 32'h0000_100C);
         chk("hold_instr_pc", instr_pc, 32'hC);
         chk("hold_pc", imem_addr, 32'hC);
         chk("hold_count", fetch_count, 32'd3);
         if (i < 4) tick();
      end
      instr_ready = 1'b1;
      ack_en = 1'b0;
      #1;
      chk("release_next_pc", next_pc, 32'h10);
      tick();
      chk("release_count", fetch_count, 32'd4);
      chk("release_addr", imem_addr, 32'h10);

      // Redirect to 0x40 while fetch is outstanding, ack 3 cycles later
      redirect_valid = 1'b1; redirect_target = 32'h40;
      tick();
      redirect_valid = 1'b0;
      chk("pend_req_kept", imem_req, 32'd1);
      chk("pend_addr_kept", imem_addr, 32'h10);
      tick();
      tick();
      ack_en = 1'b1;
      #1;
      chk("pend_next_pc", next_pc, 32'h40);
      tick();
      chk("pend_discard_valid", instr_valid, 32'd0);
      chk("pend_addr", imem_addr, 32'h40);
      chk("pend_req", imem_req, 32'd1);
      tick();
      chk("h40_valid", instr_valid, 32'd1);
      chk("h40_instr_pc", instr_pc, 32'h40);
      chk("h40_instr", instr, 32'h0000_1040);

      // Redirect to 0x80 with ready high in the same HOLD cycle
      redirect_valid = 1'b1; redirect_target = 32'h80;
      #1;
      chk("hold_redir_next_pc", next_pc, 32'h80);
      tick();
      redirect_valid = 1'b0;
      chk("hold_redir_count", fetch_count, 32'd4);
      chk("hold_redir_addr", imem_addr, 32'h80);
      chk("hold_redir_valid", instr_valid, 32'd0);
      tick();
      chk("h80_instr_pc", instr_pc, 32'h80);

      // Wrap at the top of the address space
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      chk("top_addr", imem_addr, 32'hFFFF_FFFC);
      tick();
      chk("top_instr_pc", instr_pc, 32'hFFFF_FFFC);
      chk("wrap_next_pc", next_pc, 32'h0);
      tick();
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_count", fetch_count, 32'd5);
      tick();

      // Misaligned redirect to 0x102 lands on 0x100 (trap vector or masking)
      redirect_valid = 1'b1; redirect_target = 32'h102;
      tick();
      redirect_valid = 1'b0;
      pulses = 0; got = 1'b0;
      for (int i = 0; i < 4 && !got; i++) begin
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
         if (misalign_fault) pulses++;
`endif
         if (imem_req) got = 1'b1;
         else tick();
      end
      chk("misalign_req", imem_req, 32'd1);
      chk("misalign_addr", imem_addr, 32'h100);
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
      chk("misalign_pulses", pulses, 32'd1);
`endif
      tick();
      chk("h100_instr_pc", instr_pc, 32'h100);

      // Stall blocks acceptance
      stall = 1'b1;
      #1;
      chk("stall_next_pc", next_pc, 32'h100);
      tick();
      chk("stall_valid", instr_valid, 32'd1);
      chk("stall_count", fetch_count, 32'd5);
      stall = 1'b0;
      #1;
      chk("unstall_next_pc", next_pc, 32'h104);
      tick();
      chk("unstall_count", fetch_count, 32'd6);

      // Reset mid-fetch, then a stray ack during BOOT
      reset = 1'b1;
      #1;
      chk("midrst_req", imem_req, 32'd0);
      chk("midrst_count", fetch_count, 32'd0);
      chk("midrst_valid", instr_valid, 32'd0);
      chk("midrst_instr", instr, 32'd0);
      tick();
      ack_force = 1'b1;
      reset = 1'b0;
      #1;
      chk("late_ack_next_pc", next_pc, 32'h0);
      tick();
      ack_force = 1'b0;
      chk("late_ack_valid", instr_valid, 32'd0);
      chk("late_ack_addr", imem_addr, 32'h0);
      tick();
      chk("after_rst_instr", instr, 32'h0000_1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
